// File: rtl/button_conditioner.sv
// Four-button input conditioner for the snake game top.
// Each raw button is synchronised with two flops and then debounced by a
// saturating counter. The stable levels can be priority-arbitrated to one-hot.
// A single-cycle strobe is generated on each rising edge of an output level.
module button_conditioner #(
  parameter int DEB_COUNT = 250000,
  parameter int CNT_W     = 18,
  parameter bit ONE_HOT   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_up_i,
  input  logic btn_down_i,
  input  logic btn_left_i,
  input  logic btn_right_i,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic up_pulse,
  output logic down_pulse,
  output logic left_pulse,
  output logic right_pulse,
  output logic any_press
);

  // Terminal count: once a differing sample has persisted this long, it is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_COUNT - 1);

  // Bit order everywhere: [0]=up, [1]=down, [2]=left, [3]=right
  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_st;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       w_lvl;
  logic [3:0]       r_lvl_d;
  logic [3:0]       w_pulse;

  assign w_raw = {btn_right_i, btn_left_i, btn_down_i, btn_up_i};

  // Two-flop synchroniser bringing the asynchronous buttons into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debouncer: any sample equal to the stable state restarts the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_st[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_st[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Optional priority mask up>down>left>right applied directly to the stable state
  always_comb begin
    w_lvl = r_st;
    if (!ONE_HOT) begin
      w_lvl = r_st;
    end else if (r_st[0]) begin
      w_lvl = 4'b0001;
    end else if (r_st[1]) begin
      w_lvl = 4'b0010;
    end else if (r_st[2]) begin
      w_lvl = 4'b0100;
    end else if (r_st[3]) begin
      w_lvl = 4'b1000;
    end else begin
      w_lvl = 4'b0000;
    end
  end

  // Previous-cycle copy of the output levels for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl_d <= 4'b0000;
    end else begin
      r_lvl_d <= w_lvl;
    end
  end

  // Pulses fire in the first cycle a level reads 1, including when the arbiter
  // hands the level to a lower-priority button that was already held.
  assign w_pulse = w_lvl & ~r_lvl_d;

  assign up          = w_lvl[0];
  assign down        = w_lvl[1];
  assign left        = w_lvl[2];
  assign right       = w_lvl[3];
  assign up_pulse    = w_pulse[0];
  assign down_pulse  = w_pulse[1];
  assign left_pulse  = w_pulse[2];
  assign right_pulse = w_pulse[3];
  assign any_press   = |w_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner.
// Three instances share the same buttons:
//   A: DEB_COUNT=4, ONE_HOT=1
//   B: DEB_COUNT=4, ONE_HOT=0
//   C: DEB_COUNT=1, ONE_HOT=1
// Stimulus pushes (cycle, instance, expected outputs) records.
// A monitor compares every record whose cycle matches the current edge count.
// Output vector layout: {any, rp, lp, dp, up_p, r, l, d, u}.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic b_up = 1'b0, b_dn = 1'b0, b_lf = 1'b0, b_rt = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic a_u, a_d, a_l, a_r, a_pu, a_pd, a_pl, a_pr, a_any;
  logic b_u, b_d, b_l, b_r, b_pu, b_pd, b_pl, b_pr, b_any;
  logic c_u, c_d, c_l, c_r, c_pu, c_pd, c_pl, c_pr, c_any;

  typedef struct {
    int         cyc;
    int         sel;
    logic [8:0] vec;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  button_conditioner #(.DEB_COUNT(4), .CNT_W(3), .ONE_HOT(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .btn_up_i(b_up), .btn_down_i(b_dn), .btn_left_i(b_lf), .btn_right_i(b_rt),
    .up(a_u), .down(a_d), .left(a_l), .right(a_r),
    .up_pulse(a_pu), .down_pulse(a_pd), .left_pulse(a_pl), .right_pulse(a_pr),
    .any_press(a_any));

  button_conditioner #(.DEB_COUNT(4), .CNT_W(3), .ONE_HOT(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .btn_up_i(b_up), .btn_down_i(b_dn), .btn_left_i(b_lf), .btn_right_i(b_rt),
    .up(b_u), .down(b_d), .left(b_l), .right(b_r),
    .up_pulse(b_pu), .down_pulse(b_pd), .left_pulse(b_pl), .right_pulse(b_pr),
    .any_press(b_any));

  button_conditioner #(.DEB_COUNT(1), .CNT_W(1), .ONE_HOT(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n),
    .btn_up_i(b_up), .btn_down_i(b_dn), .btn_left_i(b_lf), .btn_right_i(b_rt),
    .up(c_u), .down(c_d), .left(c_l), .right(c_r),
    .up_pulse(c_pu), .down_pulse(c_pd), .left_pulse(c_pl), .right_pulse(c_pr),
    .any_press(c_any));

  // Expected vectors (layout {any, rp, lp, dp, up_p, r, l, d, u})
  localparam logic [8:0] V_ZERO    = 9'b0_0000_0000;
  localparam logic [8:0] V_UP_P    = 9'b1_0001_0001;
  localparam logic [8:0] V_UP      = 9'b0_0000_0001;
  localparam logic [8:0] V_DN_P    = 9'b1_0010_0010;
  localparam logic [8:0] V_DN      = 9'b0_0000_0010;
  localparam logic [8:0] V_LF_P    = 9'b1_0100_0100;
  localparam logic [8:0] V_LF      = 9'b0_0000_0100;
  localparam logic [8:0] V_RT_P    = 9'b1_1000_1000;
  localparam logic [8:0] V_RT      = 9'b0_0000_1000;
  localparam logic [8:0] V_UL_P    = 9'b1_0101_0101;
  localparam logic [8:0] V_UL      = 9'b0_0000_0101;
  localparam logic [8:0] V_ALL_P   = 9'b1_1111_1111;
  localparam logic [8:0] V_ALL     = 9'b0_0000_1111;

  function automatic logic [8:0] act_vec(input int sel);
    case (sel)
      0:       act_vec = {a_any, a_pr, a_pl, a_pd, a_pu, a_r, a_l, a_d, a_u};
      1:       act_vec = {b_any, b_pr, b_pl, b_pd, b_pu, b_r, b_l, b_d, b_u};
      default: act_vec = {c_any, c_pr, c_pl, c_pd, c_pu, c_r, c_l, c_d, c_u};
    endcase
  endfunction

  task automatic expect_at(input int off, input int sel, input logic [8:0] v);
    exp_t e;
    e.cyc = cyc + off;
    e.sel = sel;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_zero_span(input int from, input int to, input int sel);
    for (int c = from; c <= to; c++) expect_at(c, sel, V_ZERO);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at this edge count, away from posedge
  always @(negedge clk) begin
    logic [8:0] act;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        act = act_vec(exp_q[i].sel);
        n_cmp = n_cmp + 1;
        if (act !== exp_q[i].vec) begin
          n_bad = n_bad + 1;
          $display("FAIL out_vec dut%0d cyc=%0d got=%b want=%b",
                   exp_q[i].sel, cyc, act, exp_q[i].vec);
        end
        exp_q.delete(i);
      end
    end
  end

  // Watchdog against a hung run
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    // 1: reset with all buttons held, then release
    b_up = 1'b1; b_dn = 1'b1; b_lf = 1'b1; b_rt = 1'b1;
    for (int s = 0; s < 3; s++) begin
      expect_at(2, s, V_ZERO);
      expect_at(5, s, V_ZERO);
      expect_at(9, s, V_ZERO);
    end
    tick(10);
    reset_n = 1'b1;
    expect_zero_span(1, 5, 0);
    expect_at(5, 1, V_ZERO);
    expect_at(6, 0, V_UP_P);
    expect_at(6, 1, V_ALL_P);
    expect_at(7, 0, V_UP);
    expect_at(7, 1, V_ALL);
    tick(10);
    b_up = 1'b0; b_dn = 1'b0; b_lf = 1'b0; b_rt = 1'b0;
    expect_at(5, 0, V_UP);
    expect_at(5, 1, V_ALL);
    expect_at(6, 0, V_ZERO);
    expect_at(6, 1, V_ZERO);
    expect_at(7, 0, V_ZERO);
    tick(10);

    // 2: clean press and release (C checks DEB_COUNT=1)
    b_up = 1'b1;
    expect_at(5, 0, V_ZERO);
    expect_at(6, 0, V_UP_P);
    expect_at(7, 0, V_UP);
    expect_at(2, 2, V_ZERO);
    expect_at(3, 2, V_UP_P);
    expect_at(4, 2, V_UP);
    tick(10);
    b_up = 1'b0;
    expect_at(2, 2, V_UP);
    expect_at(3, 2, V_ZERO);
    expect_at(5, 0, V_UP);
    expect_at(6, 0, V_ZERO);
    expect_at(7, 0, V_ZERO);
    tick(10);

    // 3: three-cycle glitch never accepted
    b_lf = 1'b1;
    expect_zero_span(1, 10, 0);
    expect_at(6, 1, V_ZERO);
    tick(3);
    b_lf = 1'b0;
    tick(10);

    // 4: bounce for 20 cycles, then hold; exactly one pulse
    expect_zero_span(1, 25, 0);
    for (int t = 0; t < 20; t++) begin
      b_dn = (t % 2 == 0) ? 1'b1 : 1'b0;
      tick(1);
    end
    b_dn = 1'b1;
    expect_zero_span(1, 5, 0);
    expect_at(6, 0, V_DN_P);
    expect_at(7, 0, V_DN);
    expect_at(8, 0, V_DN);
    expect_at(6, 1, V_DN_P);
    tick(10);
    b_dn = 1'b0;
    expect_at(6, 0, V_ZERO);
    tick(10);

    // 5: simultaneous up+left; arbitration and hand-over pulse
    b_up = 1'b1; b_lf = 1'b1;
    expect_at(5, 0, V_ZERO);
    expect_at(6, 0, V_UP_P);
    expect_at(7, 0, V_UP);
    expect_at(5, 1, V_ZERO);
    expect_at(6, 1, V_UL_P);
    expect_at(7, 1, V_UL);
    tick(10);
    b_up = 1'b0;
    expect_at(5, 0, V_UP);
    expect_at(6, 0, V_LF_P);
    expect_at(7, 0, V_LF);
    expect_at(6, 1, V_LF);
    tick(10);
    b_lf = 1'b0;
    expect_at(6, 0, V_ZERO);
    tick(10);

    // 6: reset mid-count aborts, held button restarts from reset release
    b_rt = 1'b1;
    expect_at(3, 0, V_ZERO);
    tick(3);
    reset_n = 1'b0;
    expect_at(1, 0, V_ZERO);
    expect_at(2, 0, V_ZERO);
    expect_at(2, 2, V_ZERO);
    tick(2);
    reset_n = 1'b1;
    expect_zero_span(1, 5, 0);
    expect_at(5, 1, V_ZERO);
    expect_at(6, 0, V_RT_P);
    expect_at(6, 1, V_RT_P);
    expect_at(7, 0, V_RT);
    expect_at(3, 2, V_RT_P);
    tick(10);
    b_rt = 1'b0;
    tick(10);

    k = exp_q.size();
    if (k != 0) begin
      for (int i = 0; i < k; i++) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL unchecked dut%0d cyc=%0d got=none want=%b",
                 exp_q[i].sel, exp_q[i].cyc, exp_q[i].vec);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
